// File: rtl/operator_stack.sv
// operator_stack: responder-side operator stack sharing a tristate operator bus with the controller.
// Defining OPERATOR_STACK_COUNT_EN adds a registered count output.
`ifndef OPERATOR_STACK_DEFS
`define OPERATOR_STACK_DEFS
`define SC_N 3
`define SC_NON 3'd0
`define SC_TOP 3'd1
`define SC_PUS 3'd2
`define SC_POP 3'd3
`define SC_CLR 3'd4
`define CO_N 4
`define CO_NO 4'd0
`define CO_AD 4'd1
`define CO_SB 4'd2
`define CO_ML 4'd3
`define CO_DV 4'd4
`define CO_PS 4'd5
`define CO_NS 4'd6
`endif

module operator_stack #(
   parameter int DEPTH = 16,
   parameter int AW = $clog2(DEPTH)
) (
   input logic clk,
   input logic rst,
   input logic [`SC_N-1:0] cmd,
   inout wire [`CO_N-1:0] data,
   output logic empty,
   output logic full,
   output logic error
`ifdef OPERATOR_STACK_COUNT_EN
   ,
   output logic [AW:0] count
`endif
);
   localparam logic [AW:0] ONE = (AW+1)'(1);
   localparam logic [AW:0] TWO = (AW+1)'(2);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   logic [AW:0] sp, sp_nxt;
   logic [`CO_N-1:0] top_q, top_nxt;
   logic err_q, err_nxt;
   logic [`CO_N-1:0] mem [DEPTH-1];
   logic is_top, is_pus, is_pop, is_clr, drive;
   logic [AW-1:0] wr_idx, rd_idx;
   assign is_top = cmd == `SC_TOP;
   assign is_pus = cmd == `SC_PUS;
   assign is_pop = cmd == `SC_POP;
   assign is_clr = cmd == `SC_CLR;
   assign empty = sp == '0;
   assign full = sp == FULL_CNT;
   assign error = err_q;
   assign drive = is_top | is_pop;
   assign data = drive ? (empty ? `CO_NO : top_q) : 'z;
   assign wr_idx = AW'(sp - ONE);
   assign rd_idx = AW'(sp - TWO);
   always_comb begin
      sp_nxt = sp;
      top_nxt = top_q;
      err_nxt = err_q;
      if (is_clr) begin
         sp_nxt = '0;
         top_nxt = `CO_NO;
         err_nxt = 1'b0;
      end else if (is_pus) begin
         if (full) err_nxt = 1'b1;
         else begin
            top_nxt = data;
            sp_nxt = sp + ONE;
         end
      end else if (is_pop) begin
         if (empty) err_nxt = 1'b1;
         else begin
            sp_nxt = sp - ONE;
            top_nxt = sp >= TWO ? mem[rd_idx] : `CO_NO;
         end
      end else if (is_top && empty) err_nxt = 1'b1;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sp <= '0;
         top_q <= `CO_NO;
         err_q <= 1'b0;
      end else begin
         sp <= sp_nxt;
         top_q <= top_nxt;
         err_q <= err_nxt;
      end
   end
   // only the entries below the cached top live in the array
   always_ff @(posedge clk) begin
      if (!rst && is_pus && !full && !empty) mem[wr_idx] <= top_q;
   end
`ifdef OPERATOR_STACK_COUNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) count <= '0;
      else count <= sp_nxt;
   end
`endif
endmodule

// File: tb/tb_operator_stack.sv
// tb_operator_stack: directed self-checking bench for operator_stack; the bus reads all-ones when nobody drives it.
`ifndef OPERATOR_STACK_DEFS
`define OPERATOR_STACK_DEFS
`define SC_N 3
`define SC_NON 3'd0
`define SC_TOP 3'd1
`define SC_PUS 3'd2
`define SC_POP 3'd3
`define SC_CLR 3'd4
`define CO_N 4
`define CO_NO 4'd0
`define CO_AD 4'd1
`define CO_SB 4'd2
`define CO_ML 4'd3
`define CO_DV 4'd4
`define CO_PS 4'd5
`define CO_NS 4'd6
`endif

module tb_operator_stack;
   localparam int DEPTH = 16;
   localparam logic [3:0] BUS_Z = 4'hf;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [`SC_N-1:0] cmd = `SC_NON;
   logic [`CO_N-1:0] tb_val = '0;
   logic tb_en = 1'b0;
   tri1 [`CO_N-1:0] data;
   logic empty, full, error;
   int n_chk = 0;
   int n_fail = 0;
`ifdef OPERATOR_STACK_COUNT_EN
   logic [4:0] count;
`endif
   assign data = tb_en ? tb_val : 'z;
   always #5 clk = ~clk;

   operator_stack #(.DEPTH(DEPTH), .AW(4)) dut (
      .clk(clk),
      .rst(rst),
      .cmd(cmd),
      .data(data),
      .empty(empty),
      .full(full),
      .error(error)
`ifdef OPERATOR_STACK_COUNT_EN
      ,
      .count(count)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // apply a command for one cycle, optionally driving the bus, and settle before checks
   task automatic issue(input logic [`SC_N-1:0] c, input logic [`CO_N-1:0] v = '0);
      cmd = c;
      tb_en = c == `SC_PUS;
      tb_val = v;
      #1;
   endtask

   task automatic push(input logic [`CO_N-1:0] v);
      issue(`SC_PUS, v);
      tick();
   endtask

   initial begin
      #12;
      chk("reset_empty", 32'(empty), 32'd1);
      chk("reset_full", 32'(full), 32'd0);
      chk("reset_error", 32'(error), 32'd0);
      chk("reset_bus_z", 32'(data), 32'(BUS_Z));
      @(posedge clk);
      #1 rst = 1'b0;
      tick();
      chk("idle_bus_z", 32'(data), 32'(BUS_Z));
      issue(`SC_TOP);
      chk("top_empty_bus", 32'(data), 32'(`CO_NO));
      tick();
      issue(`SC_NON);
      chk("top_empty_err", 32'(error), 32'd1);
      issue(`SC_CLR);
      chk("clr_bus_z", 32'(data), 32'(BUS_Z));
      tick();
      chk("clr_err", 32'(error), 32'd0);
      push(`CO_AD);
      push(`CO_SB);
      push(`CO_PS);
      issue(`SC_TOP);
      chk("top_ps", 32'(data), 32'(`CO_PS));
      tick();
      issue(`SC_POP);
      chk("pop1", 32'(data), 32'(`CO_PS));
      tick();
      issue(`SC_POP);
      chk("pop2", 32'(data), 32'(`CO_SB));
      tick();
      issue(`SC_POP);
      chk("pop3", 32'(data), 32'(`CO_AD));
      tick();
      issue(`SC_NON);
      chk("pops_empty", 32'(empty), 32'd1);
      chk("pops_error", 32'(error), 32'd0);
      for (int i = 0; i < DEPTH; i++) begin
         chk("fill_not_full", 32'(full), 32'd0);
         push(4'(i % 7));
      end
      issue(`SC_NON);
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_no_err", 32'(error), 32'd0);
      push(`CO_NS);
      issue(`SC_TOP);
      chk("ovf_err", 32'(error), 32'd1);
      chk("ovf_top_kept", 32'(data), 32'd1);
      chk("ovf_still_full", 32'(full), 32'd1);
      tick();
      issue(`SC_POP);
      chk("pop_16th", 32'(data), 32'd1);
      tick();
      issue(`SC_TOP);
      chk("pop_not_full", 32'(full), 32'd0);
      chk("top_15th", 32'(data), 32'd0);
      tick();
      issue(`SC_CLR);
      tick();
      push(`CO_AD);
      push(`CO_NS);
      issue(`SC_POP);
      chk("pus_pop_ns", 32'(data), 32'(`CO_NS));
      tick();
      issue(`SC_TOP);
      chk("pus_pop_restore", 32'(data), 32'(`CO_AD));
      chk("pus_pop_err", 32'(error), 32'd0);
      tick();
      issue(`SC_CLR);
      tick();
      for (int i = 0; i < DEPTH - 1; i++) push(4'(i % 5 + 1));
      for (int i = 0; i < 3; i++) begin
         push(4'(6 - i));
         issue(`SC_POP);
         chk("alt_pop", 32'(data), 32'(6 - i));
         tick();
      end
      issue(`SC_TOP);
      chk("alt_top", 32'(data), 32'(14 % 5 + 1));
      chk("alt_no_err", 32'(error), 32'd0);
      chk("alt_not_full", 32'(full), 32'd0);
      tick();
      issue(`SC_CLR);
      tick();
      for (int i = 0; i < 5; i++) push(4'(i + 1));
      issue(`SC_CLR);
      tick();
      issue(`SC_POP);
      tick();
      for (int i = 0; i < 5; i++) push(4'(i + 2));
      issue(`SC_NON);
      chk("misuse_err", 32'(error), 32'd1);
      chk("misuse_not_empty", 32'(empty), 32'd0);
      issue(`SC_CLR);
      chk("clr5_bus_z", 32'(data), 32'(BUS_Z));
      tick();
      issue(`SC_NON);
      chk("clr5_empty", 32'(empty), 32'd1);
      chk("clr5_err", 32'(error), 32'd0);
      issue(`SC_TOP);
      chk("clr5_top", 32'(data), 32'(`CO_NO));
      tick();
      issue(`SC_CLR);
      tick();
      push(`CO_AD);
      push(`CO_SB);
      push(`CO_ML);
      issue(`SC_TOP);
      tick();
      issue(`SC_POP);
      tick();
      push(`CO_ML);
      issue(`SC_NON);
      chk("pre_rst_err", 32'(error), 32'd0);
`ifdef OPERATOR_STACK_COUNT_EN
      chk("pre_rst_count", 32'(count), 32'd3);
`endif
      issue(`SC_PUS, `CO_DV);
      #2 rst = 1'b1;
      #1;
      chk("async_empty", 32'(empty), 32'd1);
      chk("async_full", 32'(full), 32'd0);
      chk("async_err", 32'(error), 32'd0);
`ifdef OPERATOR_STACK_COUNT_EN
      chk("async_count", 32'(count), 32'd0);
`endif
      tick();
      rst = 1'b0;
      issue(`SC_TOP);
      chk("post_rst_top", 32'(data), 32'(`CO_NO));
      chk("post_rst_empty", 32'(empty), 32'd1);
      tick();
      issue(`SC_NON);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/operator_stack.md
Name: operator_stack

Overview:
- Responder side of the operator-stack command interface: accepts `SC_* commands from the controller and holds the pending operators.
- Shares a bidirectional `CO_N-bit data bus with the controller. The controller drives the bus only during `SC_PUS; this block drives it during `SC_TOP and `SC_POP.
- Reports empty/full status back to the controller and flags overflow/underflow misuse.

Parameters:
- DEPTH, 16, maximum number of stored operators (at least 2).
- AW, 4, pointer width; clog2(DEPTH).

Ports:
- Clock  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- cmd  input  `SC_N  stack command: `SC_NON, `SC_TOP, `SC_PUS, `SC_POP or `SC_CLR.
- data  inout  `CO_N  shared operator bus; high-Z unless this block is driving it.
- empty  output  1  stack holds no entries.
- full  output  1  stack holds DEPTH entries.
- error  output  1  sticky flag: push-when-full or pop/top-when-empty.

Behaviour:
- State:
  - sp: entry count, AW+1 bits, range 0..DEPTH.
  - top_q: cached top-of-stack register.
  - mem[DEPTH-1]: holds the entries below the top.
  - err_q: sticky error bit.
- Reset (asynchronous, checked before any command): sp=0, top_q=`CO_NO, err_q=0, data=Z. Outputs: empty=1, full=0, error=0. Reset applied mid-command discards that command.
- Flags:
  - empty=(sp==0) and full=(sp==DEPTH), both combinational from sp.
  - error=err_q.
- Bus drive (combinational, same cycle as cmd):
  - cmd=`SC_TOP or `SC_POP: data=top_q if sp!=0, else `CO_NO.
  - All other cmd values: data=Z. The block never drives the bus during `SC_PUS.
- `SC_NON: no state change.
- Unknown encodings: treated as `SC_NON.
- `SC_TOP: no state change; bus carries the top. If empty: err_q<=1 and sp is unchanged.
- `SC_PUS:
  - Not full: the value on data is sampled at the edge. Then mem[sp-1]<=top_q (only if sp!=0), top_q<=data, sp<=sp+1.
  - Full: push is ignored, err_q<=1, contents unchanged.
  - Latency: the pushed value is visible to `SC_TOP on the next cycle.
- `SC_POP:
  - Not empty: the bus carries the old top during the cycle. At the edge sp<=sp-1, and top_q<=mem[sp-2] if sp>=2, otherwise top_q<=`CO_NO.
  - Empty: bus=`CO_NO, err_q<=1, sp stays 0.
- `SC_CLR: sp<=0, top_q<=`CO_NO, err_q<=0. Bus is Z. Memory contents are don't-care.
- Back-to-back:
  - Any command sequence at one command per cycle is legal, with no bubbles.
  - POP immediately after PUS returns the just-pushed value.
  - Alternating PUS/POP at sp=DEPTH-1 never sets error.
- Width rules:
  - sp arithmetic has no wrap-around.
  - Saturation is guaranteed by the full/empty guards above.
  - DEPTH is not required to be a power of two.

Optional Feature:
- Macro: OPERATOR_STACK_COUNT_EN.
- Defined: adds port `count  output  AW+1  current entry count (sp)`. count is registered, is 0 on reset and CLR, and updates on the same edge as sp.
- Not defined: the port is absent and sp is internal only. All other behaviour is identical.

Test Plan:
- Reset then idle -> empty=1, full=0, error=0, data=Z. TOP -> data=`CO_NO, error=1 next cycle.
- Push, one per cycle: `CO_AD, `CO_SB, `CO_PS -> TOP gives `CO_PS. Three POPs give `CO_PS, `CO_SB, `CO_AD on the bus in their respective cycles. Afterwards empty=1 and error=0.
- Push DEPTH (16) operators -> full=1. A 17th PUS -> error=1 and stack unchanged. POP then returns the 16th value and full=0.
- PUS `CO_NS followed immediately by POP -> data=`CO_NS in the POP cycle, and sp returns to its prior value.
- Push 5 entries, set error via overflow/underflow misuse, then CLR -> empty=1, error=0, data=Z. The next TOP yields `CO_NO.
- Assert Reset asynchronously (mid-cycle, during a PUS) with 3 entries stored -> outputs take reset values immediately and the push is lost. With OPERATOR_STACK_COUNT_EN: count=3 before reset, 0 after.
